// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencing controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        ERR  = 2'd3
    } fetch_state_e;

    localparam logic [3:0] PC_SEL_PLUS4  = 4'd0;
    localparam logic [3:0] PC_SEL_BRANCH = 4'd1;
    localparam logic [3:0] PC_SEL_JUMP   = 4'd2;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the fetch datapath (master) and fetch_ctrl (slave).
interface fetch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             dec_stall_in;
    logic             branch_taken_in;
    logic             jump_in;
    logic             imem_ready_in;
    logic [3:0]       pc_src_sel_out;
    logic             pc_stall_out;
    logic             imem_req_out;
    logic             if_valid_out;
    logic             redirect_ack_out;
    logic             flush_ifid_out;
    logic             flush_idex_out;
    logic             imem_err_out;
    logic [CNT_W-1:0] stall_cnt_out;

    modport master (
        output dec_stall_in, branch_taken_in, jump_in, imem_ready_in,
        input  pc_src_sel_out, pc_stall_out, imem_req_out, if_valid_out,
               redirect_ack_out, flush_ifid_out, flush_idex_out, imem_err_out,
               stall_cnt_out
    );

    modport slave (
        input  dec_stall_in, branch_taken_in, jump_in, imem_ready_in,
        output pc_src_sel_out, pc_stall_out, imem_req_out, if_valid_out,
               redirect_ack_out, flush_ifid_out, flush_idex_out, imem_err_out,
               stall_cnt_out
    );

endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear, async active-low reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: boot delay, imem wait/timeout tracking, redirect arbitration
// (branch > jump > decode stall > sequential) and the stalled-cycle counter.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int MAX_WAIT    = 15,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.slave  bus
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    fetch_state_e    r_state;
    logic [BW-1:0]   r_boot_cnt;
    logic [WW-1:0]   r_wait_cnt;
    logic [WW-1:0]   w_wait_nxt;
    logic            w_active;
    logic            w_fire;
    logic            w_acc_br;
    logic            w_acc_j;
    logic            w_stall;
    logic            w_cnt_en;
    logic            w_cnt_clr;
    logic [CNT_W-1:0] w_stall_cnt;

    assign w_wait_nxt = r_wait_cnt + WW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= BOOT;
            r_boot_cnt <= '0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                BOOT: begin
                    if (r_boot_cnt == BW'(BOOT_CYCLES - 1)) begin
                        r_state    <= RUN;
                        r_boot_cnt <= '0;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + BW'(1);
                    end
                end
                RUN: begin
                    if (!bus.imem_ready_in) begin
                        r_state    <= WAIT;
                        r_wait_cnt <= WW'(1);
                    end
                end
                WAIT: begin
                    if (bus.imem_ready_in) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (w_wait_nxt == WW'(MAX_WAIT)) begin
                        // Timeout is sticky: only reset leaves ERR.
                        r_state    <= ERR;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= w_wait_nxt;
                    end
                end
                ERR:     r_state <= ERR;
                default: r_state <= BOOT;
            endcase
        end
    end

    assign w_active = (r_state == RUN) || (r_state == WAIT);
    assign w_fire   = w_active && bus.imem_ready_in;
    assign w_acc_br = w_fire && bus.branch_taken_in;
    assign w_acc_j  = w_fire && bus.jump_in && !bus.branch_taken_in;
    // A redirect overrides the decode stall; the wrong-path instruction is squashed instead.
    assign w_stall  = !w_fire || (bus.dec_stall_in && !w_acc_br && !w_acc_j);

    assign bus.pc_src_sel_out   = w_acc_br ? PC_SEL_BRANCH :
                                  w_acc_j  ? PC_SEL_JUMP   : PC_SEL_PLUS4;
    assign bus.pc_stall_out     = w_stall;
    assign bus.imem_req_out     = w_active;
    assign bus.if_valid_out     = w_fire && !bus.dec_stall_in && !w_acc_br && !w_acc_j;
    assign bus.redirect_ack_out = w_acc_br || w_acc_j;
    assign bus.flush_ifid_out   = w_acc_br || w_acc_j;
    assign bus.flush_idex_out   = w_acc_br;
    assign bus.imem_err_out     = (r_state == ERR);

    // Counter only advances while fetching; BOOT pins it at zero, ERR freezes it.
    assign w_cnt_en  = w_active && w_stall;
    assign w_cnt_clr = (r_state == BOOT);

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (w_cnt_en),
        .clr   (w_cnt_clr),
        .count (w_stall_cnt)
    );

    assign bus.stall_cnt_out = w_stall_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl: boot, redirect priority, imem waits,
// timeout error, and stall-counter saturation.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic [3:0] sel;
        logic       stall;
        logic       req;
        logic       vld;
        logic       ack;
        logic       fi;
        logic       fx;
        logic       err;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    fetch_ctrl_if #(.CNT_W(CNT_W)) bus ();

    fetch_ctrl #(
        .BOOT_CYCLES (2),
        .MAX_WAIT    (15),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_total = 0;
    int    n_pass  = 0;

    function automatic exp_t mk(input logic [3:0] sel, input logic stall, input logic req,
                                input logic vld, input logic ack, input logic fi,
                                input logic fx, input logic err);
        exp_t e;
        e = '{sel, stall, req, vld, ack, fi, fx, err};
        return e;
    endfunction

    task automatic drive(input logic dec, input logic br, input logic j, input logic rdy);
        bus.dec_stall_in    = dec;
        bus.branch_taken_in = br;
        bus.jump_in         = j;
        bus.imem_ready_in   = rdy;
    endtask

    task automatic check_out();
        exp_t  e;
        exp_t  a;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {bus.pc_src_sel_out, bus.pc_stall_out, bus.imem_req_out, bus.if_valid_out,
             bus.redirect_ack_out, bus.flush_ifid_out, bus.flush_idex_out, bus.imem_err_out};
        n_total++;
        assert (a === e) n_pass++;
        else $error("FAIL %s: observed sel/stall/req/vld/ack/fi/fx/err=%b expected %b", t, a, e);
    endtask

    // Drive inputs at a falling edge, check the combinational response, advance one cycle.
    task automatic step(input logic dec, input logic br, input logic j, input logic rdy,
                        input exp_t e, input string tag);
        drive(dec, br, j, rdy);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        check_out();
        @(negedge clk);
    endtask

    task automatic chk_cnt(input logic [CNT_W-1:0] e, input string tag);
        n_total++;
        assert (bus.stall_cnt_out === e) n_pass++;
        else $error("FAIL %s: observed stall_cnt=%h expected %h", tag, bus.stall_cnt_out, e);
    endtask

    initial begin
        exp_t E_BOOT, E_SEQ, E_STALL, E_ERR, E_BR, E_JMP;
        E_BOOT  = mk(4'd0, 1, 0, 0, 0, 0, 0, 0);
        E_SEQ   = mk(4'd0, 0, 1, 1, 0, 0, 0, 0);
        E_STALL = mk(4'd0, 1, 1, 0, 0, 0, 0, 0);
        E_ERR   = mk(4'd0, 1, 0, 0, 0, 0, 0, 1);
        E_BR    = mk(4'd1, 0, 1, 0, 1, 1, 1, 0);
        E_JMP   = mk(4'd2, 0, 1, 0, 1, 1, 0, 0);

        drive(0, 0, 0, 0);
        @(negedge clk);
        step(0, 0, 0, 1, E_BOOT, "in_reset");
        chk_cnt('0, "cnt_in_reset");

        // Boot delay then sequential fetch
        reset = 1'b1;
        step(0, 0, 0, 1, E_BOOT, "boot_cycle0");
        step(0, 0, 0, 1, E_BOOT, "boot_cycle1");
        step(0, 0, 0, 1, E_SEQ,  "first_fetch");
        chk_cnt('0, "cnt_after_boot");

        // Branch and jump together: branch wins
        step(0, 1, 1, 1, E_BR,  "br_and_jump");
        step(0, 0, 0, 1, E_SEQ, "after_branch");

        // Jump overrides decode stall; stall alone then stalls
        step(1, 0, 1, 1, E_JMP,   "jump_over_stall");
        step(1, 0, 0, 1, E_STALL, "dec_stall_only");
        step(0, 0, 0, 1, E_SEQ,   "resume_seq");
        chk_cnt(16'd1, "cnt_after_dec_stall");

        // Branch held across imem wait states
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, E_STALL, $sformatf("br_wait_%0d", i));
        end
        step(0, 1, 0, 1, E_BR,  "br_after_wait");
        step(0, 0, 0, 1, E_SEQ, "after_wait_seq");
        chk_cnt(16'd4, "cnt_after_wait");

        // Fifteen not-ready cycles trip the sticky error
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, 0, E_STALL, $sformatf("timeout_wait_%0d", i));
        end
        step(0, 0, 0, 0, E_ERR, "err_entered");
        step(0, 1, 0, 1, E_ERR, "err_sticky_ready");
        chk_cnt(16'd19, "cnt_frozen_in_err");

        reset = 1'b0;
        step(0, 0, 0, 1, E_BOOT, "err_reset");
        chk_cnt('0, "cnt_cleared_by_reset");

        // Counter saturation under a long decode stall
        reset = 1'b1;
        step(1, 0, 0, 1, E_BOOT, "boot2_cycle0");
        step(1, 0, 0, 1, E_BOOT, "boot2_cycle1");
        step(1, 0, 0, 1, E_STALL, "long_stall_start");
        repeat (65533) @(negedge clk);
        chk_cnt(16'hFFFE, "cnt_one_below_sat");
        step(1, 0, 0, 1, E_STALL, "long_stall_mid");
        chk_cnt(16'hFFFF, "cnt_saturated");
        repeat (6) @(negedge clk);
        chk_cnt(16'hFFFF, "cnt_held_at_sat");

        reset = 1'b0;
        #1;
        chk_cnt('0, "cnt_reset_after_sat");
        step(0, 0, 0, 1, E_BOOT, "final_reset_state");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
